// File: rtl/uart_rx.sv
// uart_rx: Wishbone dbus 8N1 UART receiver with byte buffer and data-available irq.
// Define UART_RX_FIFO_EN for a 2**FIFO_BITS deep FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int unsigned       AWIDTH    = 8,
  parameter logic [AWIDTH-1:0] ADDR      = 8'h61,
  parameter int unsigned       DIVIDE    = 278,
  parameter int unsigned       FIFO_BITS = 3
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        rx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DIVIDE + 1);
  localparam logic [CW-1:0] HALF    = CW'(DIVIDE / 2);
  localparam logic [CW-1:0] FULL    = CW'(DIVIDE);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_s1_q, rx_s2_q, rx_p_q;
  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          push, ferr_set;
  logic          fall, expire;

  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;

  logic          hit, acc, pop, wr_stat;
  logic          not_empty, full, wr;
  logic [7:0]    head;

  logic unused_ok;
  assign unused_ok = ^{wb_dbus_sel, wb_dbus_dat[31:3], wb_dbus_dat[0],
                       wb_dbus_adr[31-AWIDTH:3], wb_dbus_adr[1:0]};

  assign fall   = rx_p_q & ~rx_s2_q;
  assign expire = (cnt_q == CNT_ONE);

  // two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_p_q  <= rx_s2_q;
    end
  end

  // deframing FSM: mid-bit sampling driven by the bit-period divider
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (st_q != S_IDLE) cnt_d = cnt_q - CNT_ONE;
    unique case (st_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d = HALF;
          st_d  = S_START;
        end
      end
      S_START: begin
        if (expire) begin
          if (rx_s2_q) begin
            st_d = S_IDLE;
          end else begin
            cnt_d = FULL;
            bit_d = 3'd0;
            st_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (expire) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          cnt_d = FULL;
          if (bit_q == 3'd7) st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (expire) begin
          st_d = S_IDLE;
          if (rx_s2_q) push = 1'b1;
          else         ferr_set = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // receive FSM state
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  assign hit     = wb_dbus_cyc & (wb_dbus_adr[31:32-AWIDTH] == ADDR);
  assign acc     = hit & ~ack_q & ~done_q;
  assign pop     = acc & ~wb_dbus_we & ~wb_dbus_adr[2] & not_empty;
  assign wr_stat = acc & wb_dbus_we & wb_dbus_adr[2];
  assign wr      = push & (~full | pop);

  // bus response: one ack per cycle request, read data only in the ack cycle
  always_comb begin
    ack_d  = acc;
    done_d = wb_dbus_cyc & (done_q | acc);
    rdt_d  = 32'h0;
    if (acc & ~wb_dbus_we) begin
      if (wb_dbus_adr[2]) rdt_d = {29'h0, ferr_q, ovf_q, not_empty};
      else if (not_empty) rdt_d = {24'h0, head};
    end
    ovf_d = ovf_q;
    if (wr_stat & wb_dbus_dat[1]) ovf_d = 1'b0;
    if (push & full & ~pop) ovf_d = 1'b1;
    ferr_d = ferr_q;
    if (wr_stat & wb_dbus_dat[2]) ferr_d = 1'b0;
    if (ferr_set) ferr_d = 1'b1;
  end

  // bus and status flag registers
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      rdt_q  <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      done_q <= done_d;
      rdt_q  <= rdt_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned DEPTH = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0]   FC_ONE = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS:0]   FC_MAX = (FIFO_BITS+1)'(DEPTH);
  localparam logic [FIFO_BITS-1:0] P_ONE  = FIFO_BITS'(1);

  logic [7:0]           mem_q [DEPTH];
  logic [FIFO_BITS-1:0] wp_q, rp_q;
  logic [FIFO_BITS:0]   fc_q;

  assign full      = (fc_q == FC_MAX);
  assign not_empty = (fc_q != '0);
  assign head      = mem_q[rp_q];

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + P_ONE;
      if (pop) rp_q <= rp_q + P_ONE;
      if (wr & ~pop)      fc_q <= fc_q + FC_ONE;
      else if (~wr & pop) fc_q <= fc_q - FC_ONE;
    end
  end

  // FIFO storage, contents are don't-care until written
  always_ff @(posedge wb_clk) begin
    if (wr) mem_q[wp_q] <= sh_q;
  end
`else
  logic       vld_q;
  logic [7:0] hold_q;
  logic       unused_fb;

  assign unused_fb = ^(FIFO_BITS);
  assign full      = vld_q;
  assign not_empty = vld_q;
  assign head      = hold_q;

  // single holding register with valid flag
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      if (wr)       vld_q <= 1'b1;
      else if (pop) vld_q <= 1'b0;
      if (wr) hold_q <= sh_q;
    end
  end
`endif

  assign rdt = rdt_q;
  assign ack = ack_q;
  assign irq = not_empty;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at DIVIDE=16, FIFO_BITS=2.
// Expected read data is queued at issue and checked by a monitor on ack.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = 4'hf;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

`ifdef UART_RX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  localparam logic [31:0] A_DATA = 32'h6100_0000;
  localparam logic [31:0] A_STAT = 32'h6100_0004;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  uart_rx #(
    .AWIDTH(8),
    .ADDR(8'h61),
    .DIVIDE(16),
    .FIFO_BITS(2)
  ) dut (
    .wb_clk(clk),
    .wb_rst_n(rst_n),
    .wb_dbus_adr(adr),
    .wb_dbus_dat(dat),
    .wb_dbus_sel(sel),
    .wb_dbus_we(we),
    .wb_dbus_cyc(cyc),
    .rdt(rdt),
    .ack(ack),
    .rx(rx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 want ack=0");
      end else begin
        e = sb.pop_front();
        if (e.chk) check(e.name, rdt, e.val);
      end
    end else begin
      check("rdt_idle", rdt, 32'h0);
    end
  end

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic chk,
                     input logic [31:0] exp, input string nm);
    int n = 0;
    sb.push_back(exp_t'{chk, exp, nm});
    @(negedge clk);
    cyc = 1'b1;
    adr = a;
    we  = w;
    dat = d;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got ack=0 want ack=1", nm);
      void'(sb.pop_back());
    end
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0;
    we  = 1'b0;
    adr = '0;
    dat = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    bus(1'b0, a, 32'h0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, 1'b0, 32'h0, "write");
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdt", rdt, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hA5, 1'b1);
    @(negedge clk);
    check("a5_irq", {31'h0, irq}, 32'h1);
    rd(A_STAT, 32'h1, "a5_stat");
    rd(A_DATA, 32'hA5, "a5_data");
    rd(A_STAT, 32'h0, "a5_stat_empty");
    check("a5_irq_low", {31'h0, irq}, 32'h0);

    send(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_irq", {31'h0, irq}, 32'h0);
    rd(A_STAT, 32'h4, "ferr_stat");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h0, "ferr_clr");

    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    rd(A_STAT, 32'h0, "glitch_stat");

    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    rd(A_STAT, 32'h3, "ovf_stat");
    if (FIFO) begin
      rd(A_DATA, 32'h01, "ovf_d1");
      rd(A_DATA, 32'h02, "ovf_d2");
      rd(A_DATA, 32'h03, "ovf_d3");
      rd(A_DATA, 32'h04, "ovf_d4");
      rd(A_DATA, 32'h00, "ovf_d5");
    end else begin
      rd(A_DATA, 32'h01, "ovf_d1");
      rd(A_DATA, 32'h00, "ovf_d2");
    end
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "ovf_clr");

    send(8'h11, 1'b1);
    if (FIFO) begin
      send(8'h22, 1'b1);
      send(8'h33, 1'b1);
      send(8'h44, 1'b1);
    end
    fork
      send(8'h55, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        rd(A_DATA, 32'h11, "pp_pop");
      end
    join
    rd(A_STAT, 32'h1, "pp_stat");
    if (FIFO) begin
      rd(A_DATA, 32'h22, "pp_d2");
      rd(A_DATA, 32'h33, "pp_d3");
      rd(A_DATA, 32'h44, "pp_d4");
    end
    rd(A_DATA, 32'h55, "pp_d5");
    rd(A_DATA, 32'h00, "pp_empty");

    send(8'h77, 1'b1);
    @(negedge clk);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    fork
      send(8'hFF, 1'b1);
      begin
        @(negedge clk);
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdt", rdt, 32'h0);
        check("mid_rst_ack", {31'h0, ack}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    rd(A_STAT, 32'h0, "post_rst_stat");
    send(8'h3C, 1'b1);
    @(negedge clk);
    check("3c_irq", {31'h0, irq}, 32'h1);
    rd(A_STAT, 32'h1, "3c_stat");
    rd(A_DATA, 32'h3C, "3c_data");
    rd(A_STAT, 32'h0, "3c_stat_empty");

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
